// File: rtl/mpmc11_fifo_gen.sv
// Parametrised synchronous FIFO with standard or FWFT read, almost-full threshold and reset-busy interval.
// Optional sticky overflow/underflow flags are enabled by defining MPMC11_FIFO_ERRFLAG_EN.
module mpmc11_fifo_gen #(
  parameter int WIDTH           = 64,
  parameter int DEPTH           = 32,
  parameter int AFULL_THRESH    = DEPTH - 5,
  parameter int FWFT            = 0,
  parameter int RST_BUSY_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_fifo,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rd_fifo,
  output logic [WIDTH-1:0]        dout,
  output logic                    v,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  cnt,
  output logic                    rd_rst_busy,
  output logic                    wr_rst_busy,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BSY_W = $clog2(RST_BUSY_CYCLES + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [BSY_W-1:0] busy_cnt;
  logic             busy, busy_next;
  logic             full_r, empty_r, afull_r;
  logic             wr_acc, rd_acc;

  // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    rd_acc     = rd_fifo & ~busy & ~empty_r;
    wr_acc     = wr_fifo & ~busy & (~full_r | rd_acc);
    busy_next  = (busy_cnt > BSY_W'(1));
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Status flags are forced to full/empty for the whole busy interval so neither side moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= BSY_W'(RST_BUSY_CYCLES);
      busy     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      if (busy_cnt != '0) busy_cnt <= busy_cnt - BSY_W'(1);
      busy    <= busy_next;
      count   <= count_next;
      full_r  <= busy_next | (count_next == CNT_W'(DEPTH));
      empty_r <= busy_next | (count_next == '0);
      afull_r <= (count_next >= CNT_W'(AFULL_THRESH));
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head is gated while empty so stale contents never show after reset.
      assign dout = empty_r ? '0 : mem[rd_ptr];
      assign v    = ~empty_r;
    end else begin : g_std
      logic [WIDTH-1:0] dout_r;
      logic             v_r;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_r <= '0;
          v_r    <= 1'b0;
        end else begin
          v_r <= rd_acc;
          if (rd_acc) dout_r <= mem[rd_ptr];
        end
      end
      assign dout = dout_r;
      assign v    = v_r;
    end
  endgenerate

`ifdef MPMC11_FIFO_ERRFLAG_EN
  logic ovf_r, udf_r;
  logic wr_rej, rd_rej;

  assign wr_rej = wr_fifo & ~busy & full_r & ~rd_acc;
  assign rd_rej = rd_fifo & ~busy & empty_r;

  // A fresh rejection takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= wr_rej | (ovf_r & ~err_clr);
      udf_r <= rd_rej | (udf_r & ~err_clr);
    end
  end

  assign overflow  = ovf_r;
  assign underflow = udf_r;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = afull_r;
  assign cnt         = count;
  assign rd_rst_busy = busy;
  assign wr_rst_busy = busy;

endmodule
